// File: rtl/hazard_pkg.sv
// Shared widths and FSM state type for the decode-stage issue controller.
package hazard_pkg;
  localparam int REG_W       = 5;
  localparam int NREG        = 32;
  localparam int STALL_CNT_W = 8;

  typedef enum logic {RUN, STALL} state_e;
endpackage

// File: rtl/id_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register.
// Set on issue, cleared on writeback; set wins a same-register collision.
module id_scoreboard #(
  parameter int NREG = hazard_pkg::NREG
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         set_en,
  input  logic [hazard_pkg::REG_W-1:0] set_reg,
  input  logic                         clr_en,
  input  logic [hazard_pkg::REG_W-1:0] clr_reg,
  input  logic [hazard_pkg::REG_W-1:0] rs1,
  input  logic [hazard_pkg::REG_W-1:0] rs2,
  input  logic [hazard_pkg::REG_W-1:0] rd,
  output logic [NREG-1:0]              busy,
  output logic                         rs1_busy,
  output logic                         rs2_busy,
  output logic                         rd_busy
);
  import hazard_pkg::*;

  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_busy_nxt;

  // Clear first so a same-cycle set on the same register overrides it.
  always_comb begin
    w_busy_nxt = r_busy;
    if (clr_en && clr_reg != '0) w_busy_nxt[clr_reg] = 1'b0;
    if (set_en && set_reg != '0) w_busy_nxt[set_reg] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) r_busy <= '0;
    else     r_busy <= w_busy_nxt;
  end

  assign busy     = r_busy;
  assign rs1_busy = r_busy[rs1];
  assign rs2_busy = r_busy[rs2];
  assign rd_busy  = r_busy[rd];
endmodule

// File: rtl/id_hazard_ctrl.sv
// Decode-stage issue controller: RAW/WAW hazard detection against the
// scoreboard, EX back-pressure, stall-length counter and sticky hang flag.
module id_hazard_ctrl #(
  parameter int NREG    = hazard_pkg::NREG,
  parameter int TIMEOUT = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               id_valid,
  input  logic [hazard_pkg::REG_W-1:0]       rs1,
  input  logic [hazard_pkg::REG_W-1:0]       rs2,
  input  logic [hazard_pkg::REG_W-1:0]       rd,
  input  logic                               uses_rs1,
  input  logic                               uses_rs2,
  input  logic                               writes_rd,
  input  logic                               ex_ready,
  input  logic                               wb_reg_write,
  input  logic [hazard_pkg::REG_W-1:0]       wb_write_reg,
  output logic                               issue,
  output logic                               stall,
  output logic [NREG-1:0]                    busy,
  output logic [hazard_pkg::STALL_CNT_W-1:0] stall_cnt,
  output logic                               timeout
);
  import hazard_pkg::*;

  logic                   w_rs1_busy;
  logic                   w_rs2_busy;
  logic                   w_rd_busy;
  logic                   w_hazard;
  state_e                 r_state;
  state_e                 w_state_nxt;
  logic [STALL_CNT_W-1:0] r_stall_cnt;
  logic [STALL_CNT_W-1:0] w_cnt_nxt;
  logic                   r_timeout;

  id_scoreboard #(.NREG(NREG)) u_sb (
    .clk      (clk),
    .rst      (rst),
    .set_en   (issue & writes_rd),
    .set_reg  (rd),
    .clr_en   (wb_reg_write),
    .clr_reg  (wb_write_reg),
    .rs1      (rs1),
    .rs2      (rs2),
    .rd       (rd),
    .busy     (busy),
    .rs1_busy (w_rs1_busy),
    .rs2_busy (w_rs2_busy),
    .rd_busy  (w_rd_busy)
  );

  // No bypass: a writeback only unblocks readers from the following cycle.
  assign w_hazard = (uses_rs1  & w_rs1_busy & (rs1 != '0))
                  | (uses_rs2  & w_rs2_busy & (rs2 != '0))
                  | (writes_rd & w_rd_busy  & (rd  != '0));

  assign issue = id_valid & ex_ready & ~w_hazard;
  assign stall = id_valid & ~issue;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN:     if (stall)  w_state_nxt = STALL;
      STALL:   if (!stall) w_state_nxt = RUN;
      default: w_state_nxt = RUN;
    endcase
  end

  // First stall cycle out of RUN restarts the count; saturate at all-ones.
  always_comb begin
    w_cnt_nxt = '0;
    if (stall) begin
      if (r_state == RUN)          w_cnt_nxt = STALL_CNT_W'(1);
      else if (r_stall_cnt != '1)  w_cnt_nxt = r_stall_cnt + STALL_CNT_W'(1);
      else                         w_cnt_nxt = r_stall_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= RUN;
      r_stall_cnt <= '0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_stall_cnt <= w_cnt_nxt;
      r_timeout   <= r_timeout | (w_cnt_nxt == STALL_CNT_W'(TIMEOUT));
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign timeout   = r_timeout;
endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Directed bench for id_hazard_ctrl: cycle table plus a timeout/saturation run.
module tb_id_hazard_ctrl;
  localparam int TO = 16;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic        clk = 1'b0;
  logic        rst, id_valid, uses_rs1, uses_rs2, writes_rd, ex_ready, wb_reg_write;
  logic [4:0]  rs1, rs2, rd, wb_write_reg;
  logic        issue, stall, timeout;
  logic [31:0] busy;
  logic [7:0]  stall_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_hazard_ctrl #(.NREG(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .rs1(rs1), .rs2(rs2), .rd(rd),
    .uses_rs1(uses_rs1), .uses_rs2(uses_rs2), .writes_rd(writes_rd),
    .ex_ready(ex_ready), .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg),
    .issue(issue), .stall(stall), .busy(busy), .stall_cnt(stall_cnt), .timeout(timeout)
  );

  typedef struct {
    logic rst, vld;
    logic [4:0] rs1, rs2, rd;
    logic u1, u2, wr, exr, wbr;
    logic [4:0] wbreg;
    logic e_issue, e_stall;
    logic [31:0] e_busy;
    logic [7:0] e_cnt;
    logic e_to;
  } vec_t;

  localparam int NV = 21;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic r, v, input logic [4:0] s1, s2, d,
                              input logic a1, a2, w, x, b, input logic [4:0] wreg,
                              input logic ei, es, input logic [31:0] eb,
                              input logic [7:0] ec, input logic et);
    vec_t t;
    t.rst = r; t.vld = v; t.rs1 = s1; t.rs2 = s2; t.rd = d;
    t.u1 = a1; t.u2 = a2; t.wr = w; t.exr = x; t.wbr = b; t.wbreg = wreg;
    t.e_issue = ei; t.e_stall = es; t.e_busy = eb; t.e_cnt = ec; t.e_to = et;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; id_valid = v.vld; rs1 = v.rs1; rs2 = v.rs2; rd = v.rd;
    uses_rs1 = v.u1; uses_rs2 = v.u2; writes_rd = v.wr; ex_ready = v.exr;
    wb_reg_write = v.wbr; wb_write_reg = v.wbreg;
  endtask

  // Comb outputs checked mid-cycle, registered outputs just after the edge.
  task automatic run_vec(input string nm, input vec_t v);
    @(negedge clk);
    drive(v);
    #1;
    chk({nm, " issue"}, 32'(issue), 32'(v.e_issue));
    chk({nm, " stall"}, 32'(stall), 32'(v.e_stall));
    @(posedge clk);
    #1;
    chk({nm, " busy"},    busy,           v.e_busy);
    chk({nm, " cnt"},     32'(stall_cnt), 32'(v.e_cnt));
    chk({nm, " timeout"}, 32'(timeout),   32'(v.e_to));
  endtask

  initial begin
    //            rst vld rs1   rs2   rd    u1 u2 wr ex wb wbreg  iss stl busy      cnt   to
    tbl[0]  = mk(H, H, 5'd0, 5'd0, 5'd3, L, L, H, H, L, 5'd0, H, L, 32'h0,    8'd0, L);
    tbl[1]  = mk(H, H, 5'd0, 5'd0, 5'd3, L, L, H, H, L, 5'd0, H, L, 32'h0,    8'd0, L);
    tbl[2]  = mk(L, H, 5'd2, 5'd1, 5'd3, H, H, H, H, L, 5'd0, H, L, 32'h8,    8'd0, L);
    tbl[3]  = mk(L, H, 5'd3, 5'd0, 5'd4, H, L, H, H, L, 5'd0, L, H, 32'h8,    8'd1, L);
    tbl[4]  = mk(L, H, 5'd3, 5'd0, 5'd4, H, L, H, H, L, 5'd0, L, H, 32'h8,    8'd2, L);
    tbl[5]  = mk(L, H, 5'd3, 5'd0, 5'd4, H, L, H, H, L, 5'd0, L, H, 32'h8,    8'd3, L);
    tbl[6]  = mk(L, H, 5'd3, 5'd0, 5'd4, H, L, H, H, H, 5'd3, L, H, 32'h0,    8'd4, L);
    tbl[7]  = mk(L, H, 5'd3, 5'd0, 5'd4, H, L, H, H, L, 5'd0, H, L, 32'h10,   8'd0, L);
    tbl[8]  = mk(L, H, 5'd0, 5'd0, 5'd0, H, H, H, H, L, 5'd0, H, L, 32'h10,   8'd0, L);
    tbl[9]  = mk(L, H, 5'd0, 5'd0, 5'd0, H, L, L, H, L, 5'd0, H, L, 32'h10,   8'd0, L);
    tbl[10] = mk(L, H, 5'd1, 5'd2, 5'd5, H, H, H, H, H, 5'd5, H, L, 32'h30,   8'd0, L);
    tbl[11] = mk(L, H, 5'd1, 5'd2, 5'd5, L, L, H, H, H, 5'd4, L, H, 32'h20,   8'd1, L);
    tbl[12] = mk(L, H, 5'd0, 5'd0, 5'd7, L, L, H, H, L, 5'd0, H, L, 32'hA0,   8'd0, L);
    tbl[13] = mk(L, H, 5'd0, 5'd0, 5'd7, L, L, H, H, L, 5'd0, L, H, 32'hA0,   8'd1, L);
    tbl[14] = mk(L, H, 5'd0, 5'd0, 5'd8, L, L, H, L, L, 5'd0, L, H, 32'hA0,   8'd2, L);
    tbl[15] = mk(L, L, 5'd5, 5'd7, 5'd7, H, H, H, L, L, 5'd0, L, L, 32'hA0,   8'd0, L);
    tbl[16] = mk(L, L, 5'd0, 5'd0, 5'd0, L, L, L, H, H, 5'd9, L, L, 32'hA0,   8'd0, L);
    tbl[17] = mk(H, H, 5'd0, 5'd0, 5'd5, L, L, H, H, L, 5'd0, L, H, 32'h0,    8'd0, L);
    tbl[18] = mk(L, H, 5'd0, 5'd0, 5'd5, L, L, H, H, H, 5'd5, H, L, 32'h20,   8'd0, L);
    tbl[19] = mk(L, H, 5'd0, 5'd5, 5'd6, L, H, H, H, L, 5'd0, L, H, 32'h20,   8'd1, L);
    tbl[20] = mk(L, H, 5'd0, 5'd5, 5'd6, L, L, H, H, L, 5'd0, H, L, 32'h60,   8'd0, L);

    drive(mk(H, L, 5'd0, 5'd0, 5'd0, L, L, L, L, L, 5'd0, L, L, 32'h0, 8'd0, L));
    for (int i = 0; i < NV; i++) run_vec($sformatf("vec%0d", i), tbl[i]);

    // Back-pressure hang: count past TIMEOUT up to saturation.
    run_vec("to_rst", mk(H, L, 5'd0, 5'd0, 5'd0, L, L, L, L, L, 5'd0, L, L, 32'h0, 8'd0, L));
    for (int k = 1; k <= 260; k++) begin
      logic [7:0] ec;
      ec = (k > 255) ? 8'd255 : 8'(k);
      run_vec($sformatf("hang%0d", k),
              mk(L, H, 5'd0, 5'd0, 5'd0, L, L, L, L, L, 5'd0, L, H, 32'h0, ec, (k >= TO) ? H : L));
    end
    run_vec("release",  mk(L, H, 5'd0, 5'd0, 5'd0, L, L, L, H, L, 5'd0, H, L, 32'h0, 8'd0, H));
    run_vec("sticky",   mk(L, L, 5'd0, 5'd0, 5'd0, L, L, L, H, L, 5'd0, L, L, 32'h0, 8'd0, H));
    run_vec("to_clear", mk(H, L, 5'd0, 5'd0, 5'd0, L, L, L, H, L, 5'd0, L, L, 32'h0, 8'd0, L));

    // Just short of TIMEOUT must not flag.
    for (int k = 1; k < TO; k++)
      run_vec($sformatf("short%0d", k),
              mk(L, H, 5'd0, 5'd0, 5'd0, L, L, L, L, L, 5'd0, L, H, 32'h0, 8'(k), L));
    run_vec("short_end", mk(L, L, 5'd0, 5'd0, 5'd0, L, L, L, H, L, 5'd0, L, L, 32'h0, 8'd0, L));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
